// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Parametrised up/down counter with programmable step, runtime
//               lower/upper bounds, wrap or saturate behaviour on crossing,
//               and registered overflow/underflow event pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int               WIDTH    = 16,
    parameter int               STEP_W   = 4,
    parameter int               SAT_MODE = 0,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst,        // synchronous, active-low
    input  logic              count_enb,
    input  logic              updn_cnt,   // 1 = up, 0 = down
    input  logic              ld_cnt,     // active-low parallel load
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    output logic [WIDTH-1:0]  data_out,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf,
    output logic              unf,
    output logic              cfg_err
);

    // One extra bit of headroom so that value+step and lo+step never wrap.
    localparam int C_XW = WIDTH + 1;

    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [C_XW-1:0]  w_step_x;
    logic [C_XW-1:0]  w_cur_x;
    logic [C_XW-1:0]  w_lo_x;
    logic [C_XW-1:0]  w_hi_x;
    logic [C_XW-1:0]  w_sum_x;
    logic [C_XW-1:0]  w_lo_plus_step_x;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_cfg_err;

    assign w_step_x         = {{(C_XW-STEP_W){1'b0}}, step};
    assign w_cur_x          = {1'b0, data_q};
    assign w_lo_x           = {1'b0, lo_lim};
    assign w_hi_x           = {1'b0, hi_lim};
    assign w_sum_x          = w_cur_x + w_step_x;
    assign w_lo_plus_step_x = w_lo_x + w_step_x;
    // Only used when data_q >= lo_lim + step, so the subtraction cannot wrap.
    assign w_diff           = data_q - w_step_x[WIDTH-1:0];
    assign w_cfg_err        = (lo_lim > hi_lim);

    // Load value forced into the legal window.
    assign w_load_clamped = (data_in < lo_lim) ? lo_lim :
                            (data_in > hi_lim) ? hi_lim : data_in;

    // Next-state selection: cfg error > load > count > hold.
    always_comb begin
        data_d = data_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (w_cfg_err) begin
            data_d = data_q;
        end else if (!ld_cnt) begin
            data_d = w_load_clamped;
        end else if (count_enb && (step != '0)) begin
            if (data_q < lo_lim) begin
                // Bounds moved under us: pull back in without an event.
                data_d = lo_lim;
            end else if (data_q > hi_lim) begin
                data_d = hi_lim;
            end else if (updn_cnt) begin
                if (w_sum_x <= w_hi_x) begin
                    data_d = w_sum_x[WIDTH-1:0];
                end else begin
                    data_d = (SAT_MODE != 0) ? hi_lim : lo_lim;
                    ovf_d  = 1'b1;
                end
            end else begin
                if (w_cur_x >= w_lo_plus_step_x) begin
                    data_d = w_diff;
                end else begin
                    data_d = (SAT_MODE != 0) ? lo_lim : hi_lim;
                    unf_d  = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= RST_VAL;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign data_out = data_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;
    assign at_max   = (data_q == hi_lim);
    assign at_min   = (data_q == lo_lim);
    assign cfg_err  = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_counter_param
// Description : Self-checking bench for updown_counter_param. Two instances
//               (wrap and saturate) share one stimulus stream and are checked
//               against an arithmetic reference model, a vector table and
//               hand-written corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    localparam int WIDTH  = 16;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              count_enb;
    logic              updn_cnt;
    logic              ld_cnt;
    logic [WIDTH-1:0]  data_in;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lo_lim;
    logic [WIDTH-1:0]  hi_lim;

    logic [WIDTH-1:0]  q0, q1;
    logic              amax0, amin0, ovf0, unf0, cerr0;
    logic              amax1, amin1, ovf1, unf1, cerr1;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state (values after the most recent edge).
    int  m_q[2];
    bit  m_ovf[2];
    bit  m_unf[2];

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SAT_MODE(0), .RST_VAL('0)) u_wrap (
        .clk(clk), .rst(rst), .count_enb(count_enb), .updn_cnt(updn_cnt), .ld_cnt(ld_cnt),
        .data_in(data_in), .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .data_out(q0), .at_max(amax0), .at_min(amin0), .ovf(ovf0), .unf(unf0), .cfg_err(cerr0)
    );

    updown_counter_param #(.WIDTH(WIDTH), .STEP_W(STEP_W), .SAT_MODE(1), .RST_VAL('0)) u_sat (
        .clk(clk), .rst(rst), .count_enb(count_enb), .updn_cnt(updn_cnt), .ld_cnt(ld_cnt),
        .data_in(data_in), .step(step), .lo_lim(lo_lim), .hi_lim(hi_lim),
        .data_out(q1), .at_max(amax1), .at_min(amin1), .ovf(ovf1), .unf(unf1), .cfg_err(cerr1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Counter rules in plain integer arithmetic.
    task automatic model(input int cur, input bit sat, output int nv, output bit o, output bit u);
        int lo, hi, s;
        lo = int'(lo_lim);
        hi = int'(hi_lim);
        s  = int'(step);
        nv = cur;
        o  = 1'b0;
        u  = 1'b0;
        if (!rst) begin
            nv = 0;
        end else if (lo > hi) begin
            nv = cur;
        end else if (!ld_cnt) begin
            nv = int'(data_in);
            if (nv < lo) nv = lo;
            if (nv > hi) nv = hi;
        end else if (count_enb && s != 0) begin
            if (cur < lo)      nv = lo;
            else if (cur > hi) nv = hi;
            else if (updn_cnt) begin
                if (cur + s <= hi) nv = cur + s;
                else begin nv = sat ? hi : lo; o = 1'b1; end
            end else begin
                if (cur - s >= lo) nv = cur - s;
                else begin nv = sat ? lo : hi; u = 1'b1; end
            end
        end
    endtask

    task automatic drive(input bit r, input bit en, input bit up, input bit ld,
                         input int din, input int stp, input int lo, input int hi);
        rst       = r;
        count_enb = en;
        updn_cnt  = up;
        ld_cnt    = ld;
        data_in   = WIDTH'(din);
        step      = STEP_W'(stp);
        lo_lim    = WIDTH'(lo);
        hi_lim    = WIDTH'(hi);
    endtask

    // One clock edge; both instances compared against the model afterwards.
    task automatic tick();
        int nv0, nv1;
        bit o0, u0, o1, u1;
        model(m_q[0], 1'b0, nv0, o0, u0);
        model(m_q[1], 1'b1, nv1, o1, u1);
        @(posedge clk);
        #1;
        m_q[0] = nv0; m_ovf[0] = o0; m_unf[0] = u0;
        m_q[1] = nv1; m_ovf[1] = o1; m_unf[1] = u1;
        chk("mdl_wrap_q",    int'(q0),    m_q[0]);
        chk("mdl_wrap_ovf",  int'(ovf0),  int'(m_ovf[0]));
        chk("mdl_wrap_unf",  int'(unf0),  int'(m_unf[0]));
        chk("mdl_wrap_amax", int'(amax0), int'(m_q[0] == int'(hi_lim)));
        chk("mdl_wrap_amin", int'(amin0), int'(m_q[0] == int'(lo_lim)));
        chk("mdl_wrap_cerr", int'(cerr0), int'(lo_lim > hi_lim));
        chk("mdl_sat_q",     int'(q1),    m_q[1]);
        chk("mdl_sat_ovf",   int'(ovf1),  int'(m_ovf[1]));
        chk("mdl_sat_unf",   int'(unf1),  int'(m_unf[1]));
        chk("mdl_sat_amax",  int'(amax1), int'(m_q[1] == int'(hi_lim)));
        chk("mdl_sat_amin",  int'(amin1), int'(m_q[1] == int'(lo_lim)));
        chk("mdl_sat_cerr",  int'(cerr1), int'(lo_lim > hi_lim));
    endtask

    typedef struct {
        bit r, en, up, ld;
        int din, stp, lo, hi;
        int q;
        bit ov, un;
    } vec_t;

    vec_t tbl[18];

    initial begin
        m_q[0] = 0; m_q[1] = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 100);

        // Wrap-mode vectors: {rst,en,up,ld, din,step,lo,hi, exp q,ovf,unf}
        tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,   0,3, 10, 20,   0,1'b0,1'b0}; // reset beats load/count
        tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,  18,3, 10, 20,  18,1'b0,1'b0}; // load 18
        tbl[2]  = '{1'b1,1'b1,1'b1,1'b1,   0,3, 10, 20,  10,1'b1,1'b0}; // 21>20 wraps to lo
        tbl[3]  = '{1'b1,1'b1,1'b1,1'b1,   0,3, 10, 20,  13,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b1,1'b1,   0,3, 10, 20,  16,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b1,   0,3, 10, 20,  19,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b0,  11,3, 10, 20,  11,1'b0,1'b0}; // load 11
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b1,   0,3, 10, 20,  20,1'b0,1'b1}; // 11-3<10 wraps to hi
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,   0,3, 10, 20,  17,1'b0,1'b0};
        tbl[9]  = '{1'b1,1'b1,1'b0,1'b1,   0,0, 10, 20,  17,1'b0,1'b0}; // step 0 holds
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0, 500,3, 10,200, 200,1'b0,1'b0}; // load clamps high
        tbl[11] = '{1'b1,1'b1,1'b1,1'b0,   3,3, 10,200,  10,1'b0,1'b0}; // load clamps low
        tbl[12] = '{1'b1,1'b0,1'b1,1'b0, 150,1, 10,200, 150,1'b0,1'b0};
        tbl[13] = '{1'b1,1'b1,1'b0,1'b1,   0,1, 10,120, 120,1'b0,1'b0}; // out of range clamp
        tbl[14] = '{1'b1,1'b0,1'b1,1'b0,   7,1, 50, 40, 120,1'b0,1'b0}; // cfg_err blocks load
        tbl[15] = '{1'b1,1'b1,1'b1,1'b1,   0,1, 50, 40, 120,1'b0,1'b0}; // cfg_err blocks count
        tbl[16] = '{1'b0,1'b1,1'b1,1'b0,  77,1,  0,100,   0,1'b0,1'b0}; // reset mid-activity
        tbl[17] = '{1'b1,1'b1,1'b1,1'b1,   0,1,  0,100,   1,1'b0,1'b0}; // counting resumes

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].r, tbl[i].en, tbl[i].up, tbl[i].ld,
                  tbl[i].din, tbl[i].stp, tbl[i].lo, tbl[i].hi);
            tick();
            chk($sformatf("tbl%0d_q", i),   int'(q0),   tbl[i].q);
            chk($sformatf("tbl%0d_ovf", i), int'(ovf0), int'(tbl[i].ov));
            chk($sformatf("tbl%0d_unf", i), int'(unf0), int'(tbl[i].un));
        end
        chk("cfg_err_clear", int'(cerr0), 0);

        // Saturate corner sequence on the SAT_MODE=1 instance.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 98, 7, 0, 100); tick();
        chk("sat_load98", int'(q1), 98);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 7, 0, 100); tick();
        chk("sat_up1_q", int'(q1), 100); chk("sat_up1_ovf", int'(ovf1), 1); chk("sat_up1_amax", int'(amax1), 1);
        tick();
        chk("sat_up2_q", int'(q1), 100); chk("sat_up2_ovf", int'(ovf1), 1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 5, 7, 0, 100); tick();
        chk("sat_load5", int'(q1), 5); chk("sat_load5_ovf", int'(ovf1), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 0, 7, 0, 100); tick();
        chk("sat_dn_q", int'(q1), 0); chk("sat_dn_unf", int'(unf1), 1); chk("sat_dn_amin", int'(amin1), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 7, 0, 100); tick();
        chk("sat_hold_unf", int'(unf1), 0); chk("sat_hold_q", int'(q1), 0);

        // lo == hi: every nonzero count is a crossing that stays at the bound.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 50, 2, 50, 50); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 2, 50, 50); tick();
        chk("eq_wrap_q", int'(q0), 50); chk("eq_wrap_ovf", int'(ovf0), 1);
        chk("eq_sat_q",  int'(q1), 50); chk("eq_sat_ovf",  int'(ovf1), 1);

        // Full range, step 1: modular wrap at all-ones.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1, 0, 16'hFFFF); tick();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 0, 1, 0, 16'hFFFF); tick(); tick();
        chk("full_wrap_q", int'(q0), 0); chk("full_wrap_ovf", int'(ovf0), 1);

        // Randomised stimulus against the reference model.
        for (int i = 0; i < 400; i++) begin
            int lo, hi;
            lo = int'($urandom_range(0, 40));
            hi = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 40))
                                               : lo + int'($urandom_range(0, 60));
            drive($urandom_range(0, 30) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
                  int'($urandom_range(0, 120)), int'($urandom_range(0, 15)), lo, hi);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
